// File: rtl/fetch_ins_queue_if.sv
// Fetch-to-decode link of the instruction queue: push side from fetch, head side to decode.
// Handshake: a push happens when iFeValid && oFeReady; a pop happens when oIdValid && iIdReady.
interface fetch_ins_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             iFeValid;
    logic [XLEN-1:0]  iFePc;
    logic [XLEN-1:0]  iFePcAdd4;
    logic [XLEN-1:0]  iFeIns;
    logic             oFeReady;
    logic             iFlush;
    logic             oIdValid;
    logic [XLEN-1:0]  oIdPc;
    logic [XLEN-1:0]  oIdPcAdd4;
    logic [XLEN-1:0]  oIdIns;
    logic             iIdReady;
    logic [CNT_W-1:0] oCount;
    logic             oDropErr;

    modport master (
        output iFeValid, iFePc, iFePcAdd4, iFeIns, iFlush, iIdReady,
        input  oFeReady, oIdValid, oIdPc, oIdPcAdd4, oIdIns, oCount, oDropErr
    );

    modport slave (
        input  iFeValid, iFePc, iFePcAdd4, iFeIns, iFlush, iIdReady,
        output oFeReady, oIdValid, oIdPc, oIdPcAdd4, oIdIns, oCount, oDropErr
    );
endinterface

// File: rtl/fetch_ins_queue.sv
// Circular instruction queue decoupling fetch from decode; a redirect flush empties it.
// Entries are visible to decode one cycle after the push (no bypass).
module fetch_ins_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               rst,
    fetch_ins_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             drop_err;
    logic             fe_ready;
    logic             id_valid;
    logic             push;
    logic             pop;

    logic [XLEN-1:0] mem_pc     [DEPTH];
    logic [XLEN-1:0] mem_pcadd4 [DEPTH];
    logic [XLEN-1:0] mem_ins    [DEPTH];

    // Ready depends only on registered occupancy, so a full queue refuses even during a pop.
    assign fe_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = q.iFeValid && fe_ready && !q.iFlush;
    assign pop      = id_valid && q.iIdReady && !q.iFlush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else if (q.iFlush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            drop_err <= q.iFeValid && !fe_ready;
        end
    end

    // Storage is deliberately left unreset; empty-queue outputs are masked instead.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_ptr[AW-1:0]]     <= q.iFePc;
            mem_pcadd4[wr_ptr[AW-1:0]] <= q.iFePcAdd4;
            mem_ins[wr_ptr[AW-1:0]]    <= q.iFeIns;
        end
    end

    assign q.oFeReady  = fe_ready;
    assign q.oIdValid  = id_valid;
    assign q.oIdPc     = mem_pc[rd_ptr[AW-1:0]]     & {XLEN{id_valid}};
    assign q.oIdPcAdd4 = mem_pcadd4[rd_ptr[AW-1:0]] & {XLEN{id_valid}};
    assign q.oIdIns    = mem_ins[rd_ptr[AW-1:0]]    & {XLEN{id_valid}};
    assign q.oCount    = count;
    assign q.oDropErr  = drop_err;

    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

    a_count_ptr: assert property (@(posedge clk) disable iff (rst)
        count == CNT_W'(wr_ptr - rd_ptr));

    // A valid head may only disappear through a pop, flush or reset.
    a_head_hold: assert property (@(posedge clk) disable iff (rst)
        (id_valid && !q.iIdReady && !q.iFlush) |=> id_valid);
endmodule

// File: doc/fetch_ins_queue.md
Name: fetch_ins_queue

Overview:
- Decoupling instruction queue between the fetch stage (PC generation plus icache read) and the decode stage.
- Buffers up to DEPTH fetched {Pc, PcAdd4, Ins} triples so icache-latency bubbles and decode stalls do not directly stall each other.
- Discards all buffered entries on a taken branch/jump (redirect) from the BJ bus.
- Presents the oldest entry to decode with a valid/ready handshake.

Parameters:
- XLEN, 32, width of PC, PcAdd4 and instruction fields.
- DEPTH, 4, number of queue entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- iFeValid  input  1  fetch presents a valid triple this cycle.
- iFePc  input  XLEN  PC of the fetched instruction.
- iFePcAdd4  input  XLEN  PC+4 of the fetched instruction.
- iFeIns  input  XLEN  instruction word from icache.
- oFeReady  output  1  queue can accept a push this cycle.
- iFlush  input  1  taken branch/jump redirect; discard all contents.
- oIdValid  output  1  head entry valid for decode.
- oIdPc  output  XLEN  head entry PC.
- oIdPcAdd4  output  XLEN  head entry PC+4.
- oIdIns  output  XLEN  head entry instruction.
- iIdReady  input  1  decode consumes the head entry this cycle.
- oCount  output  CNT_W  current occupancy, 0..DEPTH.
- oDropErr  output  1  one-cycle pulse; a push was attempted while not ready.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: wr/rd pointers 0, oCount 0, oIdValid 0, oDropErr 0, oFeReady 1. oIdPc/oIdPcAdd4/oIdIns read 0. Storage array contents are not reset.
- Storage: circular buffer of DEPTH entries. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty. Pointers wrap modulo 2*DEPTH with no special case at the wrap point.
- Push: iFeValid && oFeReady. Writes the triple at wr_ptr; wr_ptr+1.
- Pop: oIdValid && iIdReady. rd_ptr+1.
- oFeReady = (oCount != DEPTH). Combinational from registered state; no dependence on iIdReady, so a push into a full queue is refused even when a pop occurs in the same cycle.
- Dropped push: iFeValid && !oFeReady. Triple discarded, state unchanged, oDropErr = 1 on the next cycle for exactly one cycle.
- oIdValid = (oCount != 0).
- Output fields: head entry ANDed with oIdValid, so they are all-zero when empty. No combinational path from iFe* to oId*.
- Latency: an entry pushed in cycle N is first visible on oId* in cycle N+1 (minimum 1-cycle latency, no bypass).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- Flush (highest priority after rst): next cycle wr_ptr = rd_ptr = 0 and oCount = 0.
  - A push or pop in the flush cycle is ignored.
  - Pushes in the cycle after the flush are accepted normally; these are from the redirect target.
  - oDropErr is not raised for pushes in the flush cycle.
- Reset mid-operation: rst overrides flush/push/pop; all contents are lost.
- Order: strictly FIFO; entries are never reordered or duplicated.
- Assertions: oCount <= DEPTH; oCount == wr_ptr - rd_ptr (modulo 2*DEPTH); oIdValid stable-or-popped (a valid head is not withdrawn except by flush or rst).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release. Required: oIdValid=0, oCount=0, oFeReady=1, oIdIns=0.
- Single push: push Pc=0x200, PcAdd4=0x204, Ins=0x00000013 with iIdReady=0. Required: next cycle oIdValid=1, oIdPc=0x200, oIdIns=0x13, oCount=1. Assert iIdReady one cycle; then oIdValid=0.
- Fill/full: DEPTH=4, push Pc 0x200,0x204,0x208,0x20C with iIdReady=0. Required: oCount=4, oFeReady=0. A fifth push (0x210) gives a oDropErr pulse next cycle. Draining yields 0x200..0x20C in order; 0x210 never appears.
- Wrap-around under streaming: 20 consecutive pushes with iIdReady=1 every cycle. Required: oCount stays at 1 after the first cycle, and decode sees PCs 0x200..0x24C contiguous with no gaps or duplicates across the pointer wrap.
- Flush with simultaneous push/pop: queue holds 3 entries; assert iFlush with iFeValid=1 (Pc=0x300) and iIdReady=1. Required: next cycle oCount=0, oIdValid=0, no oDropErr. A push of Pc=0x400 in the following cycle appears as oIdPc=0x400 one cycle later.
- Reset mid-stream: queue holds 2 entries; assert rst with iFeValid=1. Required: next cycle oCount=0, oIdValid=0. Normal operation resumes after rst falls.
